// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - Time-multiplexed scanner for a common-anode 7-segment bank
// Tear-free: a newly loaded value is only applied at the frame boundary.
module seg7_scan #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [3:0]              digit,
    output logic                    digit_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] staging;
    logic                    pending;

    logic                    tick;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    blank;

    assign tick = (cnt == CNT_MAX);
    assign wrap = tick && (idx == IDX_MAX);

    // zero_from[k] is set when nibbles k..NUM_DIGITS-1 of shadow are all zero
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (shadow[4*(NUM_DIGITS-1) +: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (shadow[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        onehot = '0;
        onehot[idx] = 1'b1;
    end

    assign blank = blank_lz && (idx != '0) && zero_from[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A load coinciding with the wrap bypasses staging so it is not lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            staging <= '0;
            pending <= 1'b0;
        end else if (wrap && load) begin
            shadow  <= value;
            staging <= value;
            pending <= 1'b0;
        end else if (load) begin
            staging <= value;
            pending <= 1'b1;
        end else if (wrap && pending) begin
            shadow  <= staging;
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            digit      <= 4'h0;
            digit_en   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (blank) begin
                an       <= '1;
                digit    <= 4'h0;
                digit_en <= 1'b0;
            end else begin
                an       <= ~onehot;
                digit    <= shadow[4*idx +: 4];
                digit_en <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - Scoreboard bench for seg7_scan (4 digits, 3-cycle slots)
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  digit;
    logic        digit_en;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Expected {an, digit, digit_en, frame_done}, one entry per clock after reset release
    logic [9:0]  exp_q[$];
    int          ld_e[$];
    logic [15:0] ld_v[$];

    seg7_scan #(.NUM_DIGITS(4), .REFRESH_DIV(3)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
        .digit(digit), .digit_en(digit_en), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic void push_frame(input logic [15:0] val, input logic blk);
        logic [3:0] an_e;
        logic [3:0] nib;
        logic       bl;
        for (int s = 0; s < 4; s++) begin
            nib  = val[4*s +: 4];
            bl   = blk && (s != 0) && ((val >> (4*s)) == 16'h0);
            an_e = 4'b1111;
            if (!bl) an_e[s] = 1'b0;
            for (int r = 0; r < 3; r++) begin
                exp_q.push_back({an_e, bl ? 4'h0 : nib, !bl, (s == 3) && (r == 2)});
            end
        end
    endfunction

    task automatic assert_reset(input logic blk);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        load     = 1'b0;
        blank_lz = blk;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        ld_e.delete();
        ld_v.delete();
    endtask

    task automatic schedule_load(input int e, input logic [15:0] v);
        ld_e.push_back(e);
        ld_v.push_back(v);
    endtask

    // Drives one clock (with a scheduled load for edge k, if any) and samples outputs
    task automatic cycle(input int k, output logic [9:0] got);
        if (ld_e.size() > 0 && ld_e[0] == k) begin
            load  = 1'b1;
            value = ld_v[0];
            void'(ld_e.pop_front());
            void'(ld_v.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        got  = {an, digit, digit_en, frame_done};
    endtask

    task automatic test_reset();
        logic [9:0] got;
        logic [9:0] exp;
        int k = 0;
        assert_reset(1'b0);
        checks++;
        if ({an, digit, digit_en, frame_done} !== 10'b1111_0000_0_0) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", {an, digit, digit_en, frame_done}, 10'b1111_0000_0_0);
        end
        release_reset();
        push_frame(16'h0, 1'b0);
        while (exp_q.size() > 0) begin
            k++;
            cycle(k, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_release edge %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_scan();
        logic [9:0] got;
        logic [9:0] exp;
        int k = 0;
        assert_reset(1'b0);
        release_reset();
        schedule_load(1, 16'h1234);
        push_frame(16'h0, 1'b0);
        push_frame(16'h1234, 1'b0);
        push_frame(16'h1234, 1'b0);
        while (exp_q.size() > 0) begin
            k++;
            cycle(k, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL scan edge %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_tear_free();
        logic [9:0] got;
        logic [9:0] exp;
        int k = 0;
        assert_reset(1'b0);
        release_reset();
        schedule_load(1, 16'h1234);
        schedule_load(16, 16'hABCD);
        schedule_load(26, 16'h1111);
        schedule_load(30, 16'h2222);
        push_frame(16'h0, 1'b0);
        push_frame(16'h1234, 1'b0);
        push_frame(16'hABCD, 1'b0);
        push_frame(16'h2222, 1'b0);
        while (exp_q.size() > 0) begin
            k++;
            cycle(k, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL tear_free edge %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_load_on_wrap();
        logic [9:0] got;
        logic [9:0] exp;
        int k = 0;
        assert_reset(1'b0);
        release_reset();
        schedule_load(1, 16'h1234);
        schedule_load(20, 16'h9999);
        schedule_load(24, 16'h0F0F);
        push_frame(16'h0, 1'b0);
        push_frame(16'h1234, 1'b0);
        push_frame(16'h0F0F, 1'b0);
        push_frame(16'h0F0F, 1'b0);
        while (exp_q.size() > 0) begin
            k++;
            cycle(k, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL load_on_wrap edge %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    task automatic test_leading_zeros();
        logic [9:0] got;
        logic [9:0] exp;
        int k = 0;
        assert_reset(1'b1);
        release_reset();
        schedule_load(1, 16'h0050);
        schedule_load(13, 16'h0000);
        schedule_load(25, 16'h0001);
        push_frame(16'h0, 1'b1);
        push_frame(16'h0050, 1'b1);
        push_frame(16'h0000, 1'b1);
        push_frame(16'h0001, 1'b1);
        while (exp_q.size() > 0) begin
            k++;
            cycle(k, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL leading_zeros edge %0d: got %b want %b", k, got, exp);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [9:0] got;
        logic [9:0] exp;
        int k = 0;
        assert_reset(1'b0);
        release_reset();
        schedule_load(1, 16'h1234);
        schedule_load(14, 16'h7777);
        push_frame(16'h0, 1'b0);
        push_frame(16'h1234, 1'b0);
        while (k < 18) begin
            k++;
            cycle(k, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_pre edge %0d: got %b want %b", k, got, exp);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({an, digit, digit_en, frame_done} !== 10'b1111_0000_0_0) begin
            errors++;
            $display("FAIL async_assert: got %b want %b", {an, digit, digit_en, frame_done}, 10'b1111_0000_0_0);
        end
        release_reset();
        push_frame(16'h0, 1'b0);
        push_frame(16'h0, 1'b0);
        k = 0;
        while (exp_q.size() > 0) begin
            k++;
            cycle(k, got);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL async_after edge %0d: got %b want %b", k, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_load_on_wrap();
        test_leading_zeros();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
